inst_sram_responder: RTL and testbench



---
 rtl/inst_sram_responder_pkg.sv | 13 +
 rtl/sram_bytewrite_array.sv | 33 +++
 rtl/inst_sram_responder.sv | 113 +++++++++++
 tb/tb_inst_sram_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_responder_pkg.sv
// Shared types and defaults for the inst_sram responder.
// Holds the FSM encoding, base address and fill word.
package inst_sram_responder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEF = 32'h1C00_0000;
  localparam logic [31:0] INIT_WORD_DEF = 32'h0340_0000;

endpackage

// File: rtl/sram_bytewrite_array.sv
// Word array with byte write enables and a registered read port.
// Read-first: a write and read to one address returns the old word.
module sram_bytewrite_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/inst_sram_responder.sv
// SRAM-style responder with base-address decode and a fill engine.
// Read data is one cycle behind the request and holds while idle.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = ADDR_BASE_DEF,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] INIT_WORD  = INIT_WORD_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        init_req,
  output logic        sram_busy,
  output logic        init_done,
  output logic        sram_addr_err
);

  state_t                state;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [31:0]           off;
  logic [31:0]           arr_wdata;
  logic [31:0]           arr_rdata;
  logic [3:0]            arr_we;
  logic                  arr_re;
  logic                  valid;
  logic                  req_ok;
  logic                  rd_ok;

  assign off    = sram_addr - ADDR_BASE;
  assign idx    = off[DEPTH_LOG2+1:2];
  assign valid  = (off[31:DEPTH_LOG2+2] == '0)
               && (off[1:0] == 2'b00);
  assign req_ok = sram_en && valid;

  always_comb begin
    arr_addr  = idx;
    arr_wdata = sram_wdata;
    arr_we    = 4'h0;
    arr_re    = 1'b0;
    unique case (state)
      ST_INIT: begin
        arr_addr  = cnt;
        arr_wdata = INIT_WORD;
        arr_we    = 4'hF;
      end
      ST_READY: begin
        arr_re = req_ok;
        arr_we = req_ok ? sram_we : 4'h0;
      end
      default: ;
    endcase
  end

  sram_bytewrite_array #(
    .AW(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .resetn(resetn),
    .re    (arr_re),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // rd_ok masks the array register so idle cycles hold, rejects read 0
  assign sram_rdata = rd_ok ? arr_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_INIT;
      cnt           <= '0;
      sram_busy     <= 1'b1;
      init_done     <= 1'b0;
      sram_addr_err <= 1'b0;
      rd_ok         <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          rd_ok         <= 1'b0;
          sram_addr_err <= 1'b0;
          cnt           <= cnt + 1'b1;
          if (&cnt) begin
            cnt       <= '0;
            state     <= ST_READY;
            sram_busy <= 1'b0;
            init_done <= 1'b1;
          end
        end
        ST_READY: begin
          sram_addr_err <= sram_en && !valid;
          if (sram_en) begin
            rd_ok <= valid;
          end
          if (init_req) begin
            state     <= ST_INIT;
            cnt       <= '0;
            sram_busy <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Randomized self-checking bench for inst_sram_responder.
// A word-array model with a fill countdown predicts every output.
module tb_inst_sram_responder;

  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam logic [31:0] NOP   = 32'h0340_0000;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_req;
  logic        sram_busy;
  logic        init_done;
  logic        sram_addr_err;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_done;
  int          fill_left;
  int          checks;
  int          errors;

  inst_sram_responder #(
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(DL),
    .INIT_WORD (NOP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .init_req     (init_req),
    .sram_busy    (sram_busy),
    .init_done    (init_done),
    .sram_addr_err(sram_addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic en, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = a;
    sram_wdata = d;
  endtask

  // Advance the model by one cycle from the current inputs, then clock
  task automatic tick();
    logic [31:0] off;
    int          w;
    if (fill_left > 0) begin
      m_rdata = '0;
      m_err   = 1'b0;
      fill_left--;
      if (fill_left == 0) begin
        m_done = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = NOP;
      end
    end else begin
      if (sram_en) begin
        off = sram_addr - BASE;
        if (off < 32'(4 * DEPTH) && sram_addr[1:0] == 2'b00) begin
          w       = int'(off) / 4;
          m_rdata = m_mem[w];
          for (int b = 0; b < 4; b++)
            if (sram_we[b]) m_mem[w][8*b +: 8] = sram_wdata[8*b +: 8];
          m_err = 1'b0;
        end else begin
          m_rdata = '0;
          m_err   = 1'b1;
        end
      end else begin
        m_err = 1'b0;
      end
      if (init_req) fill_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    fill_left = DEPTH;
    m_rdata   = '0;
    m_err     = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic release_and_fill(input string tag);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'hF, BASE + 32'h40, 32'hFFFF_FFFF);
      tick();
      checks++;
      if (sram_busy !== (fill_left > 0)) begin
        errors++;
        $display("FAIL %s_busy[%0d]: got %b exp %b", tag, i,
                 sram_busy, fill_left > 0);
      end
      checks++;
      if (sram_addr_err !== 1'b0 || sram_rdata !== 32'h0) begin
        errors++;
        $display("FAIL %s_quiet[%0d]: err %b rdata %h exp 0/0", tag, i,
                 sram_addr_err, sram_rdata);
      end
    end
    checks++;
    if (sram_busy !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: busy %b done %b exp 0/1", tag,
               sram_busy, init_done);
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    init_req = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sram_rdata !== 32'h0 || sram_busy !== 1'b1 ||
        init_done !== 1'b0 || sram_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: rd %h busy %b done %b err %b exp 0/1/0/0",
               sram_rdata, sram_busy, init_done, sram_addr_err);
    end
    release_and_fill("rst");
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'h0, BASE + 32'(4 * i), $urandom);
      tick();
      checks++;
      if (sram_rdata !== NOP || sram_rdata !== m_rdata) begin
        errors++;
        $display("FAIL fill_read[%0d]: got %h exp %h", i, sram_rdata, NOP);
      end
    end
  endtask

  task automatic test_write_merge();
    drive(1'b1, 4'hF, BASE + 32'h8, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (sram_rdata !== NOP) begin
      errors++;
      $display("FAIL rd_first: got %h exp %h", sram_rdata, NOP);
    end
    drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_full: got %h exp DEADBEEF", sram_rdata);
    end
    drive(1'b1, 4'b0010, BASE + 32'h8, 32'h0000_AB00);
    tick();
    drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== 32'hDEAD_ABEF || sram_rdata !== m_rdata) begin
      errors++;
      $display("FAIL wr_byte: got %h exp DEADABEF", sram_rdata);
    end
  endtask

  task automatic test_reject();
    logic [31:0] bad [4];
    bad[0] = 32'h1BFF_FFFC;
    bad[1] = 32'h1C00_0040;
    bad[2] = 32'h1C00_0002;
    bad[3] = 32'h1C00_000A;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3) ? 4'hF : 4'h0, bad[i], 32'h5555_5555);
      tick();
      checks++;
      if (sram_rdata !== 32'h0 || sram_addr_err !== 1'b1) begin
        errors++;
        $display("FAIL reject[%0d]: rd %h err %b exp 0/1", i,
                 sram_rdata, sram_addr_err);
      end
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (sram_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got %b exp 0", sram_addr_err);
    end
    drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== 32'hDEAD_ABEF) begin
      errors++;
      $display("FAIL reject_nowr: got %h exp DEADABEF", sram_rdata);
    end
    drive(1'b1, 4'h0, BASE + 32'h3C, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== NOP || sram_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL top_word: rd %h err %b exp %h/0", sram_rdata,
               sram_addr_err, NOP);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    tick();
    drive(1'b0, 4'h0, BASE + 32'h8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sram_rdata !== NOP || sram_addr_err !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: rd %h err %b exp %h/0", i,
                 sram_rdata, sram_addr_err, NOP);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = BASE + 32'($urandom_range(0, 80)) - 32'd8;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            a, $urandom);
      tick();
      checks++;
      if (sram_rdata !== m_rdata || sram_addr_err !== m_err ||
          sram_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand[%0d]: rd %h err %b busy %b exp %h/%b/0", i,
                 sram_rdata, sram_addr_err, sram_busy, m_rdata, m_err);
      end
    end
  endtask

  task automatic test_init_req();
    logic [31:0] old;
    old = m_mem[0];
    drive(1'b1, 4'hF, BASE, 32'h1111_1111);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    checks++;
    if (sram_rdata !== old || sram_busy !== 1'b1) begin
      errors++;
      $display("FAIL ireq_serve: rd %h busy %b exp %h/1", sram_rdata,
               sram_busy, old);
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      init_req = (i == 4);
      if (i == 6) drive(1'b1, 4'h0, BASE, 32'h0);
      tick();
      checks++;
      if (sram_busy !== (i < DEPTH) || init_done !== 1'b1 ||
          sram_rdata !== 32'h0) begin
        errors++;
        $display("FAIL ireq_fill[%0d]: busy %b done %b rd %h exp %b/1/0",
                 i, sram_busy, init_done, sram_rdata, i < DEPTH);
      end
    end
    init_req = 1'b0;
    drive(1'b1, 4'h0, BASE, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== NOP || sram_rdata !== m_rdata) begin
      errors++;
      $display("FAIL ireq_refill: got %h exp %h", sram_rdata, NOP);
    end
  endtask

  task automatic test_reset_mid_fill();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (sram_busy !== 1'b1 || init_done !== 1'b0 ||
        sram_rdata !== 32'h0 || sram_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: busy %b done %b rd %h err %b exp 1/0/0/0",
               sram_busy, init_done, sram_rdata, sram_addr_err);
    end
    release_and_fill("mid");
    drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    tick();
    checks++;
    if (sram_rdata !== NOP) begin
      errors++;
      $display("FAIL mid_word: got %h exp %h", sram_rdata, NOP);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_read();
    test_write_merge();
    test_reject();
    test_hold();
    test_random();
    test_init_req();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
